// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared encodings for the multiply/divide sequencer
// Purpose: Op encodings, FSM state encodings and default widths used by
//          muldiv_sequencer and muldiv_step.
package muldiv_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DIVZ = 2'b11
  } stateT;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration of shift-add multiply / restoring divide
// Purpose: combinational single-step datapath on a 2*WIDTH accumulator.
// Ports:
//   accIn   - current accumulator {hi, lo}
//   operand - multiplicand (mult) or divisor (div), already made non-negative
//   isDiv   - 1 selects restoring divide, 0 selects shift-add multiply
//   accOut  - accumulator after this step (divide: bit 0 left clear)
//   qBit    - quotient bit produced by this step (0 in multiply mode)
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   operand,
  input  logic               isDiv,
  output logic [2*WIDTH-1:0] accOut,
  output logic               qBit
);

  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   shiftedHi;
  logic [WIDTH-1:0] trialDiff;

  always_comb begin
    // Multiply: lo holds the remaining multiplier bits, hi the partial product.
    addSum    = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
    // Divide: top WIDTH+1 bits of the accumulator shifted left by one.
    shiftedHi = accIn[2*WIDTH-1:WIDTH-1];
    // The true difference is below the divisor whenever it is used, so WIDTH bits suffice.
    trialDiff = shiftedHi[WIDTH-1:0] - operand;
    qBit      = 1'b0;
    accOut    = accIn;
    if (isDiv) begin
      qBit   = (shiftedHi >= {1'b0, operand});
      accOut = {(qBit ? trialDiff : shiftedHi[WIDTH-1:0]), accIn[WIDTH-2:0], 1'b0};
    end else begin
      accOut = {addSum, accIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative mult/multu/div/divu sequencer owning HI/LO
// Purpose: runs one radix-2 step per cycle, sign-corrects, commits HI/LO and
//          stalls the pipeline while busy.
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset
//   Start, Op           - issue request and operation (mult/multu/div/divu)
//   OperandA, OperandB  - rs / rt values; OperandA also carries mthi/mtlo data
//   Flush               - squash in-flight operation or same-cycle request
//   ReadHiLo            - mfhi/mflo wants HI/LO this cycle
//   WriteHi, WriteLo    - mthi / mtlo
//   Busy, Done, Stall   - in-flight, commit pulse, pipeline freeze
//   HiOut, LoOut        - architectural HI/LO registers
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             ReadHiLo,
  input  logic             WriteHi,
  input  logic             WriteLo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  stateT              state;
  stateT              stateNext;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operandReg;
  logic               isDiv;
  logic               signA;
  logic               signB;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;

  logic               opIsDiv;
  logic               opSigned;
  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic               divByZero;

  logic [2*WIDTH-1:0] stepAcc;
  logic               stepQBit;
  logic [2*WIDTH-1:0] productFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Operand conditioning. Negating 0x80000000 yields 0x80000000, which read
  // as unsigned is the correct magnitude.
  always_comb begin
    opIsDiv   = (Op == OP_DIV) || (Op == OP_DIVU);
    opSigned  = (Op == OP_MULT) || (Op == OP_DIV);
    aNeg      = opSigned & OperandA[WIDTH-1];
    bNeg      = opSigned & OperandB[WIDTH-1];
    aMag      = aNeg ? -OperandA : OperandA;
    bMag      = bNeg ? -OperandB : OperandB;
    divByZero = opIsDiv && (OperandB == '0);
  end

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .accIn   (acc),
    .operand (operandReg),
    .isDiv   (isDiv),
    .accOut  (stepAcc),
    .qBit    (stepQBit)
  );

  // Sign correction applied during FIX.
  always_comb begin
    productFix = (signA ^ signB) ? -acc : acc;
    quotFix    = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix     = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start && !Flush) begin
          stateNext = divByZero ? DIVZ : RUN;
        end
      end
      RUN: begin
        if (Flush) begin
          stateNext = IDLE;
        end else if (counter == LAST_CNT) begin
          stateNext = FIX;
        end
      end
      FIX, DIVZ: begin
        stateNext = IDLE;
        Done      = !Flush;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      counter    <= '0;
      acc        <= '0;
      operandReg <= '0;
      isDiv      <= 1'b0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!Flush) begin
            if (Start) begin
              isDiv   <= opIsDiv;
              signA   <= aNeg;
              signB   <= bNeg;
              counter <= '0;
              if (divByZero) begin
                // Keep the raw dividend; DIVZ hands it straight to HI.
                acc <= {{WIDTH{1'b0}}, OperandA};
              end else if (opIsDiv) begin
                acc        <= {{WIDTH{1'b0}}, aMag};
                operandReg <= bMag;
              end else begin
                acc        <= {{WIDTH{1'b0}}, bMag};
                operandReg <= aMag;
              end
            end else begin
              if (WriteHi) hiReg <= OperandA;
              if (WriteLo) loReg <= OperandA;
            end
          end
        end
        RUN: begin
          // Quotient bit drops into the slot vacated by the left shift.
          acc <= {stepAcc[2*WIDTH-1:1], stepAcc[0] | stepQBit};
          if (Flush || counter == LAST_CNT) begin
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        FIX: begin
          if (!Flush) begin
            if (isDiv) begin
              hiReg <= remFix;
              loReg <= quotFix;
            end else begin
              hiReg <= productFix[2*WIDTH-1:WIDTH];
              loReg <= productFix[WIDTH-1:0];
            end
          end
        end
        DIVZ: begin
          if (!Flush) begin
            hiReg <= acc[WIDTH-1:0];
            loReg <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy  = (state != IDLE);
  assign Stall = Busy & (Start | ReadHiLo | WriteHi | WriteLo);
  assign HiOut = hiReg;
  assign LoOut = loReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush, readHiLo, writeHi, writeLo;
  logic [1:0]  op;
  logic [31:0] operandA, operandB;
  logic        busy, done, stall;
  logic [31:0] hiOut, loOut;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Op(op),
    .OperandA(operandA), .OperandB(operandB), .Flush(flush),
    .ReadHiLo(readHiLo), .WriteHi(writeHi), .WriteLo(writeLo),
    .Busy(busy), .Done(done), .Stall(stall), .HiOut(hiOut), .LoOut(loOut)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expDone;
  } vecT;

  vecT vecs[9];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Reference: plain 64-bit arithmetic. SV signed / and % truncate toward
  // zero with the remainder taking the dividend's sign, as MIPS requires.
  function automatic logic [63:0] refModel(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    if (mop == OP_MULT) begin
      res = sa * sb;
    end else if (mop == OP_MULTU) begin
      res = ua * ub;
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (mop == OP_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      res = {ur[31:0], uq[31:0]};
    end
    return res;
  endfunction

  // Issue at cycle 0, observe cycles 1..36. Returns Done cycle (-1 none,
  // -2 more than one pulse), Busy cycle count, and HI/LO one cycle after Done.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int dc, output int bc, output logic [31:0] hiN, output logic [31:0] loN);
    op = o; operandA = a; operandB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operandA = ~a;
    operandB = ~b;
    dc = -1; bc = 0; hiN = 'x; loN = 'x;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc = (dc == -1) ? k : -2;
      if (dc > 0 && k == dc + 1) begin
        hiN = hiOut;
        loN = loOut;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          dc, bc, doneCount, stallBad;
    logic [31:0] hiN, loN, ra, rb;
    logic [1:0]  ro;
    logic [63:0] exp64;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
    vecs[4] = '{OP_DIV,   32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
    vecs[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        33};
    vecs[7] = '{OP_DIVU,  32'd5,         32'h10,       32'd5,         32'd0,         33};
    vecs[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};

    reset = 1'b1; start = 1'b0; flush = 1'b0; readHiLo = 1'b0;
    writeHi = 1'b0; writeLo = 1'b0; op = OP_MULT; operandA = '0; operandB = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    readHiLo = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stall", stall, 0);
    check("reset_hi", hiOut, 0);
    check("reset_lo", loOut, 0);
    readHiLo = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, dc, bc, hiN, loN);
      check($sformatf("vec%0d_done_cycle", i), dc, vecs[i].expDone);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].expDone);
      check($sformatf("vec%0d_hi", i), hiN, vecs[i].expHi);
      check($sformatf("vec%0d_lo", i), loN, vecs[i].expLo);
    end

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp64 = refModel(ro, ra, rb);
      runOp(ro, ra, rb, dc, bc, hiN, loN);
      check($sformatf("rand%0d_op%0d_done_cycle", i, ro), dc, (ro[1] && rb == 0) ? 1 : 33);
      check($sformatf("rand%0d_op%0d_a%0h_b%0h_hi", i, ro, ra, rb), hiN, exp64[63:32]);
      check($sformatf("rand%0d_op%0d_a%0h_b%0h_lo", i, ro, ra, rb), loN, exp64[31:0]);
    end

    // mthi/mtlo in IDLE; Flush cancels a same-cycle write.
    writeHi = 1'b1; writeLo = 1'b1; operandA = 32'h0123_4567;
    @(posedge clk); #1;
    writeHi = 1'b0; operandA = 32'h89AB_CDEF;
    @(negedge clk);
    check("write_both_hi", hiOut, 32'h0123_4567);
    check("write_both_lo", loOut, 32'h0123_4567);
    @(posedge clk); #1;
    writeLo = 1'b0;
    @(negedge clk);
    check("write_lo_only_lo", loOut, 32'h89AB_CDEF);
    check("write_lo_only_hi", hiOut, 32'h0123_4567);
    @(posedge clk); #1;
    writeHi = 1'b1; flush = 1'b1; operandA = 32'hFFFF_0000;
    @(posedge clk); #1;
    writeHi = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_cancels_write", hiOut, 32'h0123_4567);
    @(posedge clk); #1;

    // divu with mfhi waiting from cycle 5 and a second Start held from cycle 10.
    op = OP_DIVU; operandA = 32'd100; operandB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stallBad = 0;
    for (int k = 1; k <= 68; k++) begin
      readHiLo = (k >= 5 && k <= 34);
      if (k == 10) begin
        start = 1'b1; op = OP_MULTU; operandA = 32'd3; operandB = 32'd5;
      end
      if (k == 35) start = 1'b0;
      @(negedge clk);
      if (stall !== (k >= 5 && k <= 33)) stallBad++;
      if (k == 34) begin
        check("stall_c34_hi", hiOut, 32'd2);
        check("stall_c34_lo", loOut, 32'd14);
        check("stall_c34_busy", busy, 0);
      end
      if (k == 35) check("second_start_accepted_c35", busy, 1);
      if (k == 67) check("second_done_c67", done, 1);
      if (k == 68) begin
        check("second_hi", hiOut, 32'd0);
        check("second_lo", loOut, 32'd15);
      end
      @(posedge clk); #1;
    end
    readHiLo = 1'b0;
    check("stall_window_errors", stallBad, 0);

    // Flush at cycle 12 of a mult: no commit.
    op = OP_MULT; operandA = 32'd5; operandB = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    doneCount = 0;
    for (int k = 1; k <= 40; k++) begin
      flush = (k == 12);
      @(negedge clk);
      if (done) doneCount++;
      if (k == 12) check("flush_busy_c12", busy, 1);
      if (k == 13) check("flush_busy_c13", busy, 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check("flush_no_done", doneCount, 0);
    check("flush_hi_kept", hiOut, 32'd0);
    check("flush_lo_kept", loOut, 32'd15);

    // Reset at cycle 20 of a new operation.
    op = OP_MULT; operandA = 32'd5; operandB = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    doneCount = 0;
    for (int k = 1; k <= 40; k++) begin
      reset = (k == 20);
      readHiLo = (k >= 19 && k <= 21);
      @(negedge clk);
      if (done) doneCount++;
      if (k == 19) check("pre_reset_stall_c19", stall, 1);
      if (k == 21) begin
        check("post_reset_busy", busy, 0);
        check("post_reset_done", done, 0);
        check("post_reset_stall", stall, 0);
        check("post_reset_hi", hiOut, 0);
        check("post_reset_lo", loOut, 0);
      end
      @(posedge clk); #1;
    end
    readHiLo = 1'b0;
    check("reset_no_done", doneCount, 0);
    check("reset_lo_stays_zero", loOut, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide sequencer for the MIPS pipeline. Executes mult, multu, div and divu over multiple cycles and owns the HI/LO architectural registers.
- Sits beside the EX-stage ALU. The Controller decodes the instruction and drives Start/Op/ReadHiLo/WriteHi/WriteLo. This block returns Stall to the hazard logic while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  issue mult/div this cycle (EX stage)
- Op  input  2  00 mult, 01 multu, 10 div, 11 divu
- OperandA  input  WIDTH  rs value (multiplicand/dividend)
- OperandB  input  WIDTH  rt value (multiplier/divisor)
- Flush  input  1  squash in-flight operation (branch/jump/exception)
- ReadHiLo  input  1  mfhi/mflo in EX needs HI/LO
- WriteHi  input  1  mthi, data on OperandA
- WriteLo  input  1  mtlo, data on OperandA
- Busy  output  1  operation in flight
- Done  output  1  one-cycle pulse, HI/LO committed at this edge
- Stall  output  1  freeze IF/ID/EX
- HiOut  output  WIDTH  HI register
- LoOut  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, HI=LO=0, counter=0, Busy=Done=Stall=0. Reset mid-operation abandons the operation with no commit.
- FSM states:
  - IDLE: Start & !Flush latches the operands and takes absolute values for signed ops.
    - B==0 with a div op → DIVZ.
    - Otherwise → RUN, counter=0.
  - RUN: one radix-2 step per cycle (shift-add multiply / restoring divide), 2*WIDTH-bit accumulator. After WIDTH steps (counter==WIDTH-1) → FIX.
  - FIX: sign-correct the result and write HI/LO, Done=1, → IDLE.
    - Mult: negate the 64-bit product if signA^signB.
    - Div: negate the quotient if signA^signB; the remainder takes signA.
  - DIVZ: HI=OperandA as latched, LO={WIDTH{1}}, Done=1, → IDLE.
- Latency: Start sampled at edge 0. Busy is high for cycles 1..WIDTH+1 (RUN plus FIX). Done pulses in cycle WIDTH+1 (33). New HI/LO is visible from cycle 34. Div-by-zero: Busy and Done in cycle 1 only.
- Busy=1 in RUN, FIX and DIVZ.
- Stall = Busy & (Start | ReadHiLo | WriteHi | WriteLo). Combinational, so it is asserted in the same cycle as the request.
- A Start while Busy is not accepted. The held request is accepted the cycle after Busy drops.
- Priority: Reset > Flush > Start > WriteHi/WriteLo.
- Flush in RUN/FIX/DIVZ: → IDLE, no commit, Done=0, HI/LO unchanged. Flush in IDLE cancels a same-cycle Start or write.
- WriteHi/WriteLo in IDLE with no Start: write OperandA at the next edge. Both asserted writes both registers.
- HiOut/LoOut come straight from registers; there is no bypass of an in-flight result.
- Arithmetic rules:
  - Unsigned ops use raw operands.
  - Signed ops: |0x80000000| is treated as unsigned 0x80000000, which gives correct wrap behaviour.
  - The counter wraps only through the FIX transition and never overflows.

Decomposition:
- Shared package/header: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state encodings (IDLE, RUN, FIX, DIVZ), WIDTH default.
- Sub-module `muldiv_step`: combinational single-iteration datapath. Inputs: accumulator, operand, mode. Outputs: next accumulator and next quotient bit.
- The sequencer holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=7 → Done at cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB at cycle 34; Busy high cycles 1..33.
- multu A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=100, B=7 → LO=14, HI=2.
- div A=0x1234, B=0 → cycle 1 Done=1; HI=0x1234, LO=0xFFFFFFFF.
- divu issued, ReadHiLo held from cycle 5 → Stall=1 cycles 5..33, 0 at cycle 34 with LO/HI valid. Second Start at cycle 10 is stalled, then accepted at cycle 34.
- mult in flight, Flush at cycle 12 → Busy=0 at cycle 13, no Done, HI/LO keep prior values. Reset asserted at cycle 20 of a new operation → all outputs 0 next cycle.
